// File: rtl/deserializer_pkg.sv
// Shared encodings for the deserializer: beat-count width and bit-order selection.
package deserializer_pkg;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

    // Wide enough to hold N = width/lanes, so o_cnt can express every beat index.
    function automatic int beat_cnt_w(input int width, input int lanes);
        return $clog2(width / lanes + 1);
    endfunction

endpackage

// File: rtl/deserializer_if.sv
// Word-side and beat-side signals of the deserializer, grouped for port hookup.
interface deserializer_if #(
    parameter int p_width = 8,
    parameter int p_lanes = 1
) ();

    logic                                                  i_clr;
    logic [p_lanes-1:0]                                    i_val;
    logic                                                  i_stp;
    logic                                                  i_rdy;
    logic [p_width-1:0]                                    o_val;
    logic                                                  o_stp;
    logic [deserializer_pkg::beat_cnt_w(p_width, p_lanes)-1:0] o_cnt;
    logic                                                  o_ovf;

    modport master (
        output i_clr, i_val, i_stp, i_rdy,
        input  o_val, o_stp, o_cnt, o_ovf
    );

    modport slave (
        input  i_clr, i_val, i_stp, i_rdy,
        output o_val, o_stp, o_cnt, o_ovf
    );

endinterface

// File: rtl/deser_shift.sv
// Beat accumulator: shift register plus beat counter; flags the beat that completes a word.
module deser_shift
    import deserializer_pkg::*;
#(
    parameter int         p_width = 8,
    parameter int         p_lanes = 1,
    parameter bit_order_e p_order = MSB_FIRST,
    parameter int         p_cw    = beat_cnt_w(p_width, p_lanes)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic               stp_i,
    input  logic [p_lanes-1:0] val_i,
    output logic [p_width-1:0] word_o,
    output logic               done_o,
    output logic [p_cw-1:0]    cnt_o
);

    localparam int              c_beats = p_width / p_lanes;
    localparam logic [p_cw-1:0] c_last  = p_cw'(c_beats - 1);

    logic [p_width-1:0] sr_q, sr_d;
    logic [p_cw-1:0]    cnt_q, cnt_d;
    logic               last_beat;

    always_comb begin
        if (p_order == MSB_FIRST) begin
            word_o = (sr_q << p_lanes) | p_width'(val_i);
        end else begin
            word_o = (sr_q >> p_lanes) | (p_width'(val_i) << (p_width - p_lanes));
        end
    end

    assign last_beat = (cnt_q == c_last);
    assign done_o    = stp_i && !clr_i && last_beat;

    // Clear wins over a same-cycle strobe; a finished word leaves the register empty.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (stp_i) begin
            if (last_beat) begin
                sr_d  = '0;
                cnt_d = '0;
            end else begin
                sr_d  = word_o;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel converter: output holding register, ready/valid handshake and
// sticky overflow around the deser_shift accumulator.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int p_width     = 8,
    parameter int p_lanes     = 1,
    parameter int p_msb_first = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    deserializer_if.slave bus
);

    localparam bit_order_e c_order = (p_msb_first != 0) ? MSB_FIRST : LSB_FIRST;
    localparam int         c_cw    = beat_cnt_w(p_width, p_lanes);

    if ((p_width % p_lanes) != 0) begin : g_bad_ratio
        $error("deserializer: p_width must be a multiple of p_lanes");
    end

    logic [p_width-1:0] word;
    logic               done;
    logic [c_cw-1:0]    cnt;

    logic [p_width-1:0] o_val_q, o_val_d;
    logic               o_stp_q, o_stp_d;
    logic               o_ovf_q, o_ovf_d;

    deser_shift #(
        .p_width (p_width),
        .p_lanes (p_lanes),
        .p_order (c_order),
        .p_cw    (c_cw)
    ) u_shift (
        .clk_i   (i_clk),
        .rst_n_i (i_rst),
        .clr_i   (bus.i_clr),
        .stp_i   (bus.i_stp),
        .val_i   (bus.i_val),
        .word_o  (word),
        .done_o  (done),
        .cnt_o   (cnt)
    );

    // A word arriving while the held one is stalled is dropped, not queued.
    always_comb begin
        o_val_d = o_val_q;
        o_stp_d = o_stp_q;
        o_ovf_d = o_ovf_q;
        if (o_stp_q && bus.i_rdy) begin
            o_stp_d = 1'b0;
        end
        if (done) begin
            if (o_stp_q && !bus.i_rdy) begin
                o_ovf_d = 1'b1;
            end else begin
                o_val_d = word;
                o_stp_d = 1'b1;
            end
        end
        if (bus.i_clr) begin
            o_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_val_q <= '0;
            o_stp_q <= 1'b0;
            o_ovf_q <= 1'b0;
        end else begin
            o_val_q <= o_val_d;
            o_stp_q <= o_stp_d;
            o_ovf_q <= o_ovf_d;
        end
    end

    assign bus.o_val = o_val_q;
    assign bus.o_stp = o_stp_q;
    assign bus.o_cnt = cnt;
    assign bus.o_ovf = o_ovf_q;

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter p_width, default 8: output word width in bits.
REQ-002 SHALL have parameter p_lanes, default 1: serial bits accepted per strobe; p_width SHALL be an integer multiple of p_lanes.
REQ-003 SHALL have parameter p_msb_first, default 1: 1 = first beat lands in the MSBs, 0 = first beat lands in the LSBs.
REQ-004 SHALL have ports: i_clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have ports: i_rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: i_clr  in  1  synchronous discard of the partial word.
REQ-007 SHALL have ports: i_val  in  p_lanes  serial data beat; bit p_lanes-1 is the most significant.
REQ-008 SHALL have ports: i_stp  in  1  beat strobe; i_val sampled when high.
REQ-009 SHALL have ports: i_rdy  in  1  consumer ready for o_val.
REQ-010 SHALL have ports: o_val  out  p_width  assembled word.
REQ-011 SHALL have ports: o_stp  out  1  o_val valid; held until accepted.
REQ-012 SHALL have ports: o_cnt  out  clog2(p_width/p_lanes+1)  beats in the partial word.
REQ-013 SHALL have ports: o_ovf  out  1  sticky overflow flag.

Function
REQ-014 SHALL accumulate beats in a shift register; the beat count runs 0..N-1, where N = p_width/p_lanes.
REQ-015 SHALL, when p_msb_first=1, shift left by p_lanes per beat and insert i_val at the LSBs.
REQ-016 SHALL, when p_msb_first=0, shift right by p_lanes per beat and insert i_val at the MSBs.
REQ-017 SHALL, on the N-th beat, load the completed word into the output holding register, reset the beat count to 0 and clear the shift register in the same edge.
REQ-018 SHALL assert o_stp on the cycle after the final-beat strobe; latency is 1 clock.
REQ-019 SHALL accept the output word when o_stp and i_rdy are both high; o_stp deasserts the next cycle unless a new word loads in that same edge.
REQ-020 SHALL keep o_val and o_stp stable while o_stp=1 and i_rdy=0.
REQ-021 SHALL, when a word completes while o_stp=1 and i_rdy=0, drop the new word, keep the held word and set o_ovf.
REQ-022 SHALL, when a word completes while o_stp=1 and i_rdy=1, load the new word with no overflow; o_stp stays high.
REQ-023 SHALL, on i_clr, zero the shift register and beat count, with priority over a simultaneous i_stp (that beat is discarded).
REQ-024 SHALL NOT let i_clr affect the holding register or o_stp.
REQ-025 SHALL clear o_ovf only by reset or by i_clr.
REQ-026 SHALL ignore i_val when i_stp=0.
REQ-027 SHALL give o_cnt the current beat count, registered.

Reset
REQ-028 SHALL, while i_rst=0, asynchronously force: shift register 0, beat count 0, o_val 0, o_stp 0, o_cnt 0, o_ovf 0.
REQ-029 SHALL, on reset mid-word or with a word held, discard all data; the first strobe after release is beat 0.
REQ-030 SHALL release reset synchronously with i_clk; deassertion synchronisation is the integrator's responsibility.

Structure
REQ-031 SHALL place in the shared encode package: a beat-count width function, clog2(p_width/p_lanes+1), and a bit-order enum (MSB_FIRST, LSB_FIRST).
REQ-032 SHALL implement the shift register plus beat counter as sub-module deser_shift; the top level holds the output register, handshake and overflow logic.
REQ-033 SHALL contain a single clock domain and no combinational path from i_rdy to o_stp.

Verification
REQ-034 SHALL test p_width=8, p_lanes=1, msb-first: bits 1,0,1,1,0,0,1,0 strobed, i_rdy=1 -> o_val=8'hB2, o_stp high exactly 1 cycle, 1 clock after the 8th strobe.
REQ-035 SHALL test the same bits with p_msb_first=0 -> o_val=8'h4D.
REQ-036 SHALL test p_lanes=2, msb-first: beats 2'b10, 2'b11, 2'b00, 2'b01 -> o_val=8'hB1 after the 4th beat; o_cnt steps 1, 2, 3, 0.
REQ-037 SHALL test i_rdy=0 while a second word 8'h55 completes over the held 8'hB2 -> o_val stays 8'hB2, o_ovf=1; then i_rdy=1 -> o_stp drops, o_ovf stays 1 until i_clr.
REQ-038 SHALL test i_clr after 3 beats, then 8 new beats of 8'hFF -> o_val=8'hFF, with the earlier beats absent.
REQ-039 SHALL test i_rst=0 pulsed asynchronously between edges with 5 beats pending and a word held -> all outputs 0 immediately; the next 8 beats form one clean word.
